// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a four-state sequencer.
//
// Build option: define FETCH_CYCLE_CNT_EN to enable the saturating
// execution-cycle counter on CycleCnt. When it is undefined, CycleCnt is tied to 0.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   synchronous, active-low reset
//   Start      in   launch/relaunch the program (accepted only in IDLE/HALT)
//   InstrIn    in   9-bit ROM word addressed by ProgCtr (combinational ROM)
//   Jen/Taken  in   jump request and branch condition from decode
//   Jptr       in   8-bit absolute jump target
//   stall      in   current instruction needs one extra cycle
//   Done       in   current instruction is the halt instruction
//   ProgCtr    out  ROM address
//   mach_code  out  registered instruction to decode
//   Valid      out  mach_code is live; qualifies all downstream writes
//   Halted     out  program finished
//   CycleCnt   out  execution cycle count
module fetch_unit #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      InstrIn,
  input  logic            Jen,
  input  logic [7:0]      Jptr,
  input  logic            Taken,
  input  logic            stall,
  input  logic            Done,
  output logic [PC_W-1:0] ProgCtr,
  output logic [8:0]      mach_code,
  output logic            Valid,
  output logic            Halted,
  output logic [15:0]     CycleCnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      mach_q, mach_d;
  logic            vld_q, vld_d;
  logic            halt_q, halt_d;

  logic [PC_W-1:0] jptr_ext;
  logic            start_ok;

  assign jptr_ext = PC_W'(Jptr);
  assign start_ok = Start && ((state_q == S_IDLE) || (state_q == S_HALT));

  // Next-state and registered-output logic. Decode inputs only matter in RUN
  // with a live instruction; the priority chain is Done > jump > stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mach_d  = mach_q;
    vld_d   = vld_q;
    halt_d  = halt_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          mach_d  = '0;
          vld_d   = 1'b0;
          halt_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (vld_q && Done) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          vld_d   = 1'b0;
        end else if (vld_q && Jen && Taken) begin
          // The word currently on InstrIn is the wrong path: flush it.
          pc_d   = jptr_ext;
          mach_d = '0;
          vld_d  = 1'b0;
        end else if (vld_q && stall) begin
          state_d = S_STALL;
          vld_d   = 1'b0;
        end else begin
          mach_d = InstrIn;
          vld_d  = 1'b1;
          pc_d   = pc_q + 1'b1;
        end
      end
      S_STALL: begin
        // The stall cycle itself fetches so only one bubble is produced.
        state_d = S_RUN;
        mach_d  = InstrIn;
        vld_d   = 1'b1;
        pc_d    = pc_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      mach_q  <= '0;
      vld_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mach_q  <= mach_d;
      vld_q   <= vld_d;
      halt_q  <= halt_d;
    end
  end

  assign ProgCtr   = pc_q;
  assign mach_code = mach_q;
  assign Valid     = vld_q;
  assign Halted    = halt_q;

`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts every RUN/STALL cycle, saturates, freezes in IDLE/HALT.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (((state_q == S_RUN) || (state_q == S_STALL)) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CycleCnt = cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign CycleCnt        = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized phase, all
// checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;
  localparam int PC_W  = 10;
  localparam int DEPTH = 1 << PC_W;

  logic            Clk = 1'b0;
  logic            Reset, Start, Jen, Taken, stall, Done;
  logic [7:0]      Jptr;
  logic [8:0]      InstrIn;
  logic [PC_W-1:0] ProgCtr;
  logic [8:0]      mach_code;
  logic            Valid, Halted;
  logic [15:0]     CycleCnt;

  logic [8:0] rom [0:DEPTH-1];

  always #5 Clk = ~Clk;

  assign InstrIn = rom[ProgCtr];

  fetch_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstrIn(InstrIn),
    .Jen(Jen), .Jptr(Jptr), .Taken(Taken), .stall(stall), .Done(Done),
    .ProgCtr(ProgCtr), .mach_code(mach_code), .Valid(Valid),
    .Halted(Halted), .CycleCnt(CycleCnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: program position, output word and a few flags
  int         m_pc;
  logic [8:0] m_code;
  bit         m_code_known;
  bit         m_valid, m_halted, m_active, m_in_stall;
  int         m_cnt;

  task automatic model_step();
    bit fetch = 1'b0;
    bit counting;
    if (!Reset) begin
      m_pc = 0; m_code = '0; m_code_known = 1'b1; m_valid = 1'b0;
      m_halted = 1'b0; m_active = 1'b0; m_in_stall = 1'b0; m_cnt = 0;
      return;
    end
    counting = m_active;
    if (!m_active) begin
      if (Start) begin
        m_active = 1'b1; m_halted = 1'b0; m_valid = 1'b0; m_pc = 0;
        m_code_known = 1'b0; m_cnt = 0;
      end
    end else if (m_in_stall) begin
      m_in_stall = 1'b0;
      fetch = 1'b1;
    end else if (m_valid && Done) begin
      m_active = 1'b0; m_halted = 1'b1; m_valid = 1'b0;
    end else if (m_valid && Jen && Taken) begin
      m_pc = int'(Jptr); m_code = '0; m_code_known = 1'b1; m_valid = 1'b0;
    end else if (m_valid && stall) begin
      m_in_stall = 1'b1; m_valid = 1'b0;
    end else begin
      fetch = 1'b1;
    end
    if (fetch) begin
      m_code = rom[m_pc]; m_code_known = 1'b1; m_valid = 1'b1;
      m_pc = (m_pc + 1) % DEPTH;
    end
    if (counting && m_cnt < 65535) m_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_cnt;
`ifdef FETCH_CYCLE_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check("ProgCtr", 32'(ProgCtr), 32'(m_pc));
    if (m_code_known) check("mach_code", 32'(mach_code), 32'(m_code));
    check("Valid", 32'(Valid), 32'(m_valid));
    check("Halted", 32'(Halted), 32'(m_halted));
    check("CycleCnt", 32'(CycleCnt), 32'(exp_cnt));
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    Start = 1'b0; Jen = 1'b0; Taken = 1'b0; stall = 1'b0; Done = 1'b0; Jptr = 8'h00;
  endtask

  task automatic random_decode();
    Jen   = ($urandom_range(0, 3) == 0);
    Taken = ($urandom_range(0, 1) == 1);
    stall = ($urandom_range(0, 5) == 0);
    Done  = ($urandom_range(0, 24) == 0);
    Jptr  = 8'($urandom);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 9'($urandom_range(0, 511));
    rom[0] = 9'h011;
    rom[1] = 9'h022;

    // Reset wins over Start and every decode input
    Reset = 1'b0; Start = 1'b1; Jen = 1'b1; Taken = 1'b1; stall = 1'b1; Done = 1'b1;
    Jptr = 8'h55;
    tick();
    tick();
    check("rst_pc", 32'(ProgCtr), 32'h0);
    check("rst_code", 32'(mach_code), 32'h0);

    // Out of reset without Start: no fetch
    idle_inputs();
    Reset = 1'b1;
    repeat (3) tick();
    check("idle_pc", 32'(ProgCtr), 32'h0);
    check("idle_vld", 32'(Valid), 32'h0);

    // Launch and sequential fetch
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_pc", 32'(ProgCtr), 32'h0);
    check("start_vld", 32'(Valid), 32'h0);
    tick();
    check("f0_code", 32'(mach_code), 32'h011);
    check("f0_pc", 32'(ProgCtr), 32'h1);
    check("f0_vld", 32'(Valid), 32'h1);
    tick();
    check("f1_code", 32'(mach_code), 32'h022);
    check("f1_pc", 32'(ProgCtr), 32'h2);
    repeat (3) tick();
    check("at_pc5", 32'(ProgCtr), 32'h5);

    // Taken jump: one bubble then the target word
    Jen = 1'b1; Taken = 1'b1; Jptr = 8'h20;
    tick();
    idle_inputs();
    check("jmp_vld", 32'(Valid), 32'h0);
    check("jmp_pc", 32'(ProgCtr), 32'h020);
    tick();
    check("jmp_code", 32'(mach_code), 32'(rom[32'h20]));
    check("jmp_vld2", 32'(Valid), 32'h1);

    // Not-taken jump: sequential
    Jen = 1'b1; Taken = 1'b0; Jptr = 8'h40;
    tick();
    idle_inputs();
    check("nt_pc", 32'(ProgCtr), 32'h022);
    check("nt_vld", 32'(Valid), 32'h1);

    // Stall on the instruction fetched from address 3
    Jen = 1'b1; Taken = 1'b1; Jptr = 8'h03;
    tick();
    idle_inputs();
    tick();
    check("pre_stall_pc", 32'(ProgCtr), 32'h4);
    check("pre_stall_code", 32'(mach_code), 32'(rom[3]));
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("stall_vld", 32'(Valid), 32'h0);
    check("stall_pc", 32'(ProgCtr), 32'h4);
    tick();
    check("post_stall_code", 32'(mach_code), 32'(rom[4]));
    check("post_stall_pc", 32'(ProgCtr), 32'h5);

    // Randomized traffic, including occasional reset and ignored Starts
    for (int k = 0; k < 500; k++) begin
      Reset = ($urandom_range(0, 99) != 0);
      Start = ($urandom_range(0, 9) == 0);
      random_decode();
      tick();
    end

    // Back to a known running program
    idle_inputs();
    Reset = 1'b0;
    tick();
    Reset = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();

    // Done beats a simultaneous taken jump
    Done = 1'b1; Jen = 1'b1; Taken = 1'b1; Jptr = 8'h77;
    tick();
    idle_inputs();
    check("halt_flag", 32'(Halted), 32'h1);
    check("halt_pc", 32'(ProgCtr), 32'h2);
    for (int k = 0; k < 6; k++) begin
      random_decode();
      tick();
    end
    idle_inputs();
    check("halt_hold", 32'(Halted), 32'h1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("restart_pc", 32'(ProgCtr), 32'h0);
    check("restart_halt", 32'(Halted), 32'h0);
    check("restart_cnt", 32'(CycleCnt), 32'h0);

    // Sequential run to the top of the address space and wrap
    tick();
    Jen = 1'b1; Taken = 1'b1; Jptr = 8'hFF;
    tick();
    idle_inputs();
    for (int k = 0; k < 1100 && ProgCtr != 10'h3FF; k++) tick();
    check("reach_3ff", 32'(ProgCtr), 32'h3FF);
    tick();
    check("wrap_pc", 32'(ProgCtr), 32'h0);
    check("wrap_code", 32'(mach_code), 32'(rom[DEPTH-1]));

    // Reset while in STALL
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("stall2_vld", 32'(Valid), 32'h0);
    Reset = 1'b0; Start = 1'b1; Jen = 1'b1; Taken = 1'b1; Done = 1'b1;
    tick();
    check("rst_stall_pc", 32'(ProgCtr), 32'h0);
    check("rst_stall_code", 32'(mach_code), 32'h0);
    check("rst_stall_vld", 32'(Valid), 32'h0);
    idle_inputs();
    Reset = 1'b1;
    repeat (3) tick();
    check("post_rst_pc", 32'(ProgCtr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, 10, program-counter width in bits; SHALL be at least 8.
REQ-002 Parameter: RESET_PC, 0, program address loaded at reset and at every Start.
REQ-003 Port: Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: Reset  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 Port: Start  input  1  launch or relaunch the program; honoured only in IDLE or HALT.
REQ-006 Port: InstrIn  input  9  instruction word read combinationally from instruction ROM at ProgCtr.
REQ-007 Port: Jen  input  1  jump request from the decode stage.
REQ-008 Port: Jptr  input  8  absolute jump target from the decode stage.
REQ-009 Port: Taken  input  1  branch condition; jump occurs only if Jen and Taken are both 1.
REQ-010 Port: stall  input  1  current instruction needs one extra cycle.
REQ-011 Port: Done  input  1  current instruction is the halt instruction.
REQ-012 Port: ProgCtr  output  PC_W  instruction ROM address.
REQ-013 Port: mach_code  output  9  registered instruction presented to the decode stage.
REQ-014 Port: Valid  output  1  mach_code is a live instruction; downstream SHALL gate all register and memory writes with it.
REQ-015 Port: Halted  output  1  program has finished.
REQ-016 Port: CycleCnt  output  16  execution cycle count.

Function
REQ-017 FSM states SHALL be IDLE, RUN, STALL and HALT.
REQ-018 Decode inputs (Jen, Taken, stall, Done) SHALL be acted on only in RUN with Valid=1; otherwise they SHALL be ignored.
REQ-019 IDLE or HALT with Start=1: next cycle ProgCtr=RESET_PC, Halted=0, Valid=0, state RUN.
REQ-020 Start SHALL be ignored in RUN and STALL.
REQ-021 Each RUN cycle with no event: mach_code<=InstrIn, Valid<=1, ProgCtr<=ProgCtr+1.
REQ-022 Fetch latency SHALL be one cycle: the word at address A appears on mach_code with Valid=1 in the cycle after ProgCtr=A.
REQ-023 ProgCtr SHALL wrap from all-ones to 0 with no flag.
REQ-024 Jump (Valid, Jen, Taken): ProgCtr<={zero-extend Jptr to PC_W}, mach_code<=0, Valid<=0, state stays RUN; the in-flight word is flushed.
REQ-025 Jen=1 with Taken=0 SHALL behave as a plain RUN cycle (REQ-021).
REQ-026 Stall (Valid, stall): state<=STALL, ProgCtr and mach_code held, Valid<=0.
REQ-027 STALL SHALL last exactly one cycle and then return to RUN, resuming with REQ-021 behaviour; the stall input is ignored while in STALL.
REQ-028 Done (Valid, Done): state<=HALT, Halted<=1, Valid<=0, ProgCtr and mach_code held.
REQ-029 When events coincide, priority SHALL be Done > jump > stall.
REQ-030 HALT SHALL hold all outputs until Start or Reset.

Reset
REQ-031 Reset=0 at a clock edge SHALL force state=IDLE, ProgCtr=RESET_PC, mach_code=0, Valid=0, Halted=0, CycleCnt=0.
REQ-032 Reset SHALL take precedence over Start and all decode inputs, including mid-program and mid-STALL.
REQ-033 After Reset returns to 1, no fetch SHALL occur until Start=1.

Configuration
REQ-034 Macro FETCH_CYCLE_CNT_EN defined: CycleCnt SHALL increment on every RUN or STALL cycle, clear to 0 on an accepted Start, saturate at 16'hFFFF, and freeze in HALT.
REQ-035 Macro FETCH_CYCLE_CNT_EN undefined: CycleCnt SHALL be constant 0, with no counter logic inferred.

Verification
REQ-036 Reset=0 then Start=1 with ROM[0]=9'h011, ROM[1]=9'h022 -> mach_code 9'h011 then 9'h022, Valid=1; ProgCtr steps 0,1,2.
REQ-037 At PC 5, Jen=1, Taken=1, Jptr=8'h20 -> one Valid=0 bubble, ProgCtr=10'h020, next valid mach_code=ROM[0x20]; repeat with Taken=0 -> sequential fetch continues.
REQ-038 stall=1 on a valid instruction at PC 3 -> one cycle with Valid=0, ProgCtr held at 4, then ROM[4] issued; CycleCnt includes the stall cycle when FETCH_CYCLE_CNT_EN is defined.
REQ-039 Done=1 and Jen=1, Taken=1 in the same cycle -> HALT, Halted=1, no jump; then Start=1 -> ProgCtr=RESET_PC, Halted=0, CycleCnt=0.
REQ-040 ProgCtr=10'h3FF in RUN -> wraps to 0; Reset=0 during STALL -> IDLE, all outputs at reset values next cycle.
